// File: rtl/adar_spi_pkg.sv
// adar_spi_pkg: shared state type, frame geometry and field positions for the ADAR1000 SPI engine
package adar_spi_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int FRAME_BITS = 24;
    localparam int RW_BIT     = 23;
    localparam int CHIP_MSB   = 22;
    localparam int CHIP_LSB   = 21;
    localparam int ADDR_MSB   = 20;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic        rw,
        input logic [1:0]  chip,
        input logic [12:0] addr,
        input logic [7:0]  data
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[CHIP_MSB:CHIP_LSB] = chip;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction
endpackage

// File: rtl/adar_spi_clkgen.sv
// adar_spi_clkgen: SCLK half-period divider; sclk idles low while disabled, rise/fall strobe on the toggling cycle
module adar_spi_clkgen
    import adar_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       wrap;

    assign wrap   = en_i && (cnt_q == 8'(CLK_DIV - 1));
    assign rise_o = wrap && !sclk_q;
    assign fall_o = wrap && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        cnt_d  = (!en_i || wrap) ? 8'd0 : cnt_q + 8'd1;
        sclk_d = en_i && (sclk_q ^ wrap);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= 8'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end
endmodule

// File: rtl/adar_spi_engine.sv
// adar_spi_engine: mode-0 SPI master serialising one 24-bit ADAR1000 frame per command.
// Define ADAR_SPI_READBACK_EN to capture MISO and return read data on rsp_data.
module adar_spi_engine
    import adar_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [4:0]            bit_q, bit_d;
    logic [7:0]            wait_q, wait_d;
    logic [7:0]            rd_q, rd_d, rsp_next;
    logic                  cs_n_q, cs_n_d;
    logic                  rv_q, rv_d;
    logic                  ready_q, ready_d;
    logic                  hs, sclk_en, rise, fall, sclk;

    assign hs      = cmd_valid && ready_q;
    assign sclk_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

    adar_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clock  (clock),
        .reset  (reset),
        .en_i   (sclk_en),
        .sclk_o (sclk),
        .rise_o (rise),
        .fall_o (fall)
    );

`ifdef ADAR_SPI_READBACK_EN
    logic [7:0] cap_q, cap_d;
    logic       rw_q, rw_d;

    // 24 rising edges fully flush the capture register, so it never needs clearing per frame
    assign cap_d    = rise ? {cap_q[6:0], spi_miso} : cap_q;
    assign rw_d     = hs ? cmd_data[RW_BIT] : rw_q;
    assign rsp_next = rw_q ? cap_q : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_q <= 8'h00;
            rw_q  <= 1'b0;
        end else begin
            cap_q <= cap_d;
            rw_q  <= rw_d;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rsp_next    = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        cs_n_d  = cs_n_q;
        rv_d    = 1'b0;
        rd_d    = rd_q;
        ready_d = ready_q;
        case (state_q)
            ST_IDLE: if (hs) begin
                state_d = ST_SETUP;
                sh_d    = cmd_data;
                bit_d   = 5'd0;
                cs_n_d  = 1'b0;
                ready_d = 1'b0;
            end
            ST_SETUP: state_d = rise ? ST_SHIFT : ST_SETUP;
            // MOSI is the shift register MSB; clearing it on the last edge drives MOSI low in HOLD
            ST_SHIFT: if (fall) begin
                state_d = (bit_q == 5'(FRAME_BITS - 1)) ? ST_HOLD : ST_SHIFT;
                sh_d    = (bit_q == 5'(FRAME_BITS - 1)) ? '0 : sh_q << 1;
                bit_d   = bit_q + 5'd1;
                wait_d  = 8'd0;
            end
            ST_HOLD: if (wait_q == 8'(CLK_DIV - 1)) begin
                state_d = ST_GAP;
                wait_d  = 8'd0;
                cs_n_d  = 1'b1;
                rv_d    = 1'b1;
                rd_d    = rsp_next;
            end else begin
                wait_d = wait_q + 8'd1;
            end
            ST_GAP: if (wait_q == 8'(GAP_CYCLES - 1)) begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bit_q   <= 5'd0;
            wait_q  <= 8'd0;
            cs_n_q  <= 1'b1;
            rv_q    <= 1'b0;
            rd_q    <= 8'h00;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            cs_n_q  <= cs_n_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign spi_sclk  = sclk;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = sh_q[FRAME_BITS-1];
    assign rsp_valid = rv_q;
    assign rsp_data  = rd_q;
endmodule

// File: tb/tb_adar_spi_engine.sv
// tb_adar_spi_engine: randomized self-checking bench with an SPI slave model and frame-timing reference
module tb_adar_spi_engine;
    import adar_spi_pkg::*;

    localparam int D  = 4;
    localparam int G  = 8;
    localparam int D2 = 2;
    localparam int G2 = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, busy, spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso  = 1'b0;
    logic [23:0] cmd_data  = '0;
    logic [7:0]  rsp_data;

    logic        cmd_valid2 = 1'b0, cmd_ready2, rsp_valid2, busy2, sclk2, cs_n2, mosi2;
    logic        miso2      = 1'b0;
    logic [23:0] cmd_data2  = '0;
    logic [7:0]  rsp_data2;

    adar_spi_engine #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    adar_spi_engine #(.CLK_DIV(D2), .GAP_CYCLES(G2)) dut2 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_data(cmd_data2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2),
        .spi_sclk(sclk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(miso2)
    );

    // Mode-0 slave: presents its MSB when selected, moves to the next bit on each SCLK fall
    logic [23:0] slave_word = '0;
    logic [23:0] sw = '0;
    logic        cs_p = 1'b1, sclk_p = 1'b0;
    always @(negedge clock) begin
        cs_p   <= spi_cs_n;
        sclk_p <= spi_sclk;
        if (!spi_cs_n && cs_p) begin
            sw       <= slave_word;
            spi_miso <= slave_word[23];
        end else if (!spi_cs_n && sclk_p && !spi_sclk) begin
            sw       <= sw << 1;
            spi_miso <= sw[22];
        end
    end

    function automatic logic [7:0] exp_rsp(input logic [23:0] d, input logic [7:0] b);
`ifdef ADAR_SPI_READBACK_EN
        return d[23] ? b : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    // Drives one command and records what the bus did, relative to the handshake cycle
    task automatic capture(
        input  logic [23:0] data, input logic [7:0] sbyte,
        input  int next_at, input logic [23:0] next_data,
        output int t_hs, output logic [23:0] bits, output int nrise, output int cs_low,
        output int rv_at, output int nrv, output logic [7:0] rdata, output int rdy_at,
        output logic busy1
    );
        logic sp;
        sp = 1'b0; t_hs = -1; bits = '0; nrise = 0; cs_low = 0;
        rv_at = -1; nrv = 0; rdata = 8'h00; rdy_at = -1; busy1 = 1'b0;
        slave_word = {16'($urandom), sbyte};
        cmd_valid  = 1'b1;
        cmd_data   = data;
        for (int i = 0; i < 1000 && t_hs < 0; i++) begin
            if (cmd_ready) t_hs = cyc;
            else @(negedge clock);
        end
        if (t_hs < 0) return;
        for (int i = 1; i < 49 * D + G + 100; i++) begin
            @(negedge clock);
            if (i == next_at) begin
                cmd_valid = 1'b1;
                cmd_data  = next_data;
            end else if (i == 1) begin
                cmd_valid = 1'b0;
            end
            if (i == 1) busy1 = busy;
            if (!spi_cs_n) cs_low++;
            if (spi_sclk && !sp) begin
                bits = {bits[22:0], spi_mosi};
                nrise++;
            end
            sp = spi_sclk;
            if (rsp_valid) begin
                nrv++;
                rv_at = cyc - t_hs;
                rdata = rsp_data;
            end
            if (cmd_ready) begin
                rdy_at = cyc - t_hs;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    endtask

    task automatic test_write_frame();
        int t, nr, low, rv, nrv, rdy;
        logic [23:0] bits;
        logic [7:0]  rd;
        logic        b1;
        capture(24'h0008A5, 8'($urandom), -1, '0, t, bits, nr, low, rv, nrv, rd, rdy, b1);
        checks++; if (bits !== 24'h0008A5) begin errors++; $display("FAIL write_bits got %h exp 0008a5", bits); end
        checks++; if (nr !== 24) begin errors++; $display("FAIL write_nrise got %0d exp 24", nr); end
        checks++; if (low !== 49 * D) begin errors++; $display("FAIL write_cs_low got %0d exp %0d", low, 49 * D); end
        checks++; if (rv !== 1 + 49 * D) begin errors++; $display("FAIL write_rsp_time got %0d exp %0d", rv, 1 + 49 * D); end
        checks++; if (nrv !== 1) begin errors++; $display("FAIL write_rsp_pulses got %0d exp 1", nrv); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_rsp_data got %h exp 00", rd); end
        checks++; if (rdy !== 1 + 49 * D + G) begin errors++; $display("FAIL write_ready_time got %0d exp %0d", rdy, 1 + 49 * D + G); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", b1); end
    endtask

    task automatic test_read_frame();
        int t, nr, low, rv, nrv, rdy;
        logic [23:0] bits;
        logic [7:0]  rd;
        logic        b1;
        capture(24'h802C00, 8'h5C, -1, '0, t, bits, nr, low, rv, nrv, rd, rdy, b1);
        checks++; if (bits !== 24'h802C00) begin errors++; $display("FAIL read_bits got %h exp 802c00", bits); end
        checks++; if (rd !== exp_rsp(24'h802C00, 8'h5C)) begin errors++; $display("FAIL read_rsp_data got %h exp %h", rd, exp_rsp(24'h802C00, 8'h5C)); end
        checks++; if (rv !== 1 + 49 * D) begin errors++; $display("FAIL read_rsp_time got %0d exp %0d", rv, 1 + 49 * D); end
    endtask

    task automatic test_random_frames();
        int t, nr, low, rv, nrv, rdy;
        logic [23:0] bits, d;
        logic [7:0]  rd, b;
        logic        b1;
        for (int n = 0; n < 8; n++) begin
            d = make_frame(1'($urandom), 2'($urandom), 13'($urandom), 8'($urandom));
            b = 8'($urandom);
            capture(d, b, -1, '0, t, bits, nr, low, rv, nrv, rd, rdy, b1);
            checks++; if (bits !== d) begin errors++; $display("FAIL rand_bits[%0d] got %h exp %h", n, bits, d); end
            checks++; if (rd !== exp_rsp(d, b)) begin errors++; $display("FAIL rand_rsp_data[%0d] got %h exp %h", n, rd, exp_rsp(d, b)); end
            checks++; if (rsp_data !== exp_rsp(d, b)) begin errors++; $display("FAIL rand_rsp_hold[%0d] got %h exp %h", n, rsp_data, exp_rsp(d, b)); end
            checks++; if (rv !== 1 + 49 * D) begin errors++; $display("FAIL rand_rsp_time[%0d] got %0d exp %0d", n, rv, 1 + 49 * D); end
            checks++; if (rdy !== 1 + 49 * D + G) begin errors++; $display("FAIL rand_ready_time[%0d] got %0d exp %0d", n, rdy, 1 + 49 * D + G); end
        end
    endtask

    // Second command either held from the start (next_at=1) or raised mid-frame (next_at=60)
    task automatic run_pair(input string name, input int next_at);
        int t1, t2, nr, low, rv1, rv2, nrv, rdy;
        logic [23:0] bits1, bits2, d1, d2;
        logic [7:0]  rd, b2;
        logic        b1;
        d1 = make_frame(1'b0, 2'($urandom), 13'($urandom), 8'($urandom));
        d2 = make_frame(1'b1, 2'($urandom), 13'($urandom), 8'($urandom));
        b2 = 8'($urandom);
        capture(d1, 8'($urandom), next_at, d2, t1, bits1, nr, low, rv1, nrv, rd, rdy, b1);
        capture(d2, b2, -1, '0, t2, bits2, nr, low, rv2, nrv, rd, rdy, b1);
        checks++; if (bits1 !== d1) begin errors++; $display("FAIL %s_bits1 got %h exp %h", name, bits1, d1); end
        checks++; if (bits2 !== d2) begin errors++; $display("FAIL %s_bits2 got %h exp %h", name, bits2, d2); end
        checks++; if (t2 - t1 !== 1 + 49 * D + G) begin errors++; $display("FAIL %s_accept got %0d exp %0d", name, t2 - t1, 1 + 49 * D + G); end
        checks++; if ((t2 + 1) - (t1 + rv1) !== G + 1) begin errors++; $display("FAIL %s_cs_high got %0d exp %0d", name, (t2 + 1) - (t1 + rv1), G + 1); end
        checks++; if (rd !== exp_rsp(d2, b2)) begin errors++; $display("FAIL %s_rsp2 got %h exp %h", name, rd, exp_rsp(d2, b2)); end
    endtask

    task automatic test_back_to_back();
        run_pair("b2b", 1);
    endtask

    task automatic test_ignore_busy();
        run_pair("busy_ignore", 60);
    endtask

    task automatic test_reset_midframe();
        int t, n, nrv, nlow;
        logic sp;
        t = -1; n = 0; nrv = 0; nlow = 0; sp = 1'b0;
        slave_word = 24'($urandom);
        cmd_data   = make_frame(1'b1, 2'($urandom), 13'($urandom), 8'h00);
        cmd_valid  = 1'b1;
        for (int i = 0; i < 1000 && t < 0; i++) begin
            if (cmd_ready) t = cyc;
            else @(negedge clock);
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2000 && n < 10; i++) begin
            if (spi_sclk && !sp) n++;
            sp = spi_sclk;
            if (n < 10) @(negedge clock);
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL rstmid_edges got %0d exp 10", n); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n got %b exp 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got %b exp 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rstmid_mosi got %b exp 0", spi_mosi); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) nrv++;
            if (!spi_cs_n) nlow++;
            @(negedge clock);
        end
        checks++; if (nrv !== 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d exp 0", nrv); end
        checks++; if (nlow !== 0) begin errors++; $display("FAIL rstmid_cs_idle got %0d exp 0", nlow); end
    endtask

    task automatic test_fast_params();
        int t, rv, rdy, low;
        t = -1; rv = -1; rdy = -1; low = 0;
        cmd_data2  = make_frame(1'b0, 2'($urandom), 13'($urandom), 8'($urandom));
        cmd_valid2 = 1'b1;
        for (int i = 0; i < 100 && t < 0; i++) begin
            if (cmd_ready2) t = cyc;
            else @(negedge clock);
        end
        for (int i = 0; i < 300 && rdy < 0; i++) begin
            @(negedge clock);
            cmd_valid2 = 1'b0;
            if (!cs_n2) low++;
            if (rsp_valid2) rv = cyc - t;
            if (cmd_ready2) rdy = cyc - t;
        end
        checks++; if (rv !== 1 + 49 * D2) begin errors++; $display("FAIL fast_rsp_time got %0d exp %0d", rv, 1 + 49 * D2); end
        checks++; if (rdy !== 1 + 49 * D2 + G2) begin errors++; $display("FAIL fast_ready_time got %0d exp %0d", rdy, 1 + 49 * D2 + G2); end
        checks++; if (low !== 49 * D2) begin errors++; $display("FAIL fast_cs_low got %0d exp %0d", low, 49 * D2); end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_read_frame();
        test_random_frames();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_fast_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
